// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache controller: FSM states, line geometry
// and byte-address field extraction.
package dcache_pkg;

  localparam int OFFSET_W = 2;
  localparam int WORDS    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_RD,
    S_DRAIN,
    S_DONE
  } state_t;

  // Word offset within a line (bit 0 is the byte lane and is ignored).
  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [15:0] addr);
    return addr[OFFSET_W:1];
  endfunction

  // Line index, right-aligned; caller trims to its index width.
  function automatic logic [15:0] addr_index(input logic [15:0] addr, input int index_w);
    return (addr >> (OFFSET_W + 1)) & ((16'd1 << index_w) - 16'd1);
  endfunction

  // Tag bits above the index, right-aligned; caller trims to its tag width.
  function automatic logic [15:0] addr_tag(input logic [15:0] addr, input int index_w);
    return addr >> (index_w + OFFSET_W + 1);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for a direct-mapped cache of 4-word lines.
// Combinational read of one word plus line metadata; synchronous writes.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [15:0]         rd_word,
  input  logic                data_we,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [15:0]         wr_data,
  input  logic                meta_we,
  input  logic [TAG_W-1:0]    meta_tag,
  input  logic                meta_valid,
  input  logic                meta_dirty
);

  localparam int LINES = 1 << INDEX_W;

  logic [15:0]      data_mem [LINES*WORDS];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_bits;
  logic [LINES-1:0] dirty_bits;

  assign rd_word  = data_mem[{index, rd_offset}];
  assign rd_tag   = tag_mem[index];
  assign rd_valid = valid_bits[index];
  assign rd_dirty = dirty_bits[index];

  // Data words and tags are plain storage with no reset.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[{index, wr_offset}] <= wr_data;
    if (meta_we) tag_mem[index] <= meta_tag;
  end

  // Valid/dirty flags must come up cleared so no stale line ever hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (meta_we) begin
      valid_bits[index] <= meta_valid;
      dirty_bits[index] <= meta_dirty;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller. Hits finish
// in the request cycle; misses write back a dirty victim, refill 4 words and
// complete in a DONE cycle while stall holds the pipeline.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [15:0] resp_data,
  output logic        done,
  output logic        stall,
  output logic        cache_req,
  output logic        cache_hit,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_stall,
  input  logic [15:0] mem_rdata
);

  localparam int TAG_W = 16 - INDEX_W - OFFSET_W - 1;

  state_t state, state_next;
  logic [OFFSET_W-1:0] k;        // word counter for write-back / refill issue
  logic [OFFSET_W-1:0] cap_cnt;  // refill words captured so far
  logic [15:0] lat_addr, lat_wdata;
  logic        lat_wr;
  logic [MEM_LAT-1:0]               trk_v;
  logic [MEM_LAT-1:0][OFFSET_W-1:0] trk_k;

  logic [15:0]         cur_addr, cur_wdata;
  logic                cur_wr, any_req, hit, capture, rd_accept;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    cur_tag, rd_tag;
  logic [OFFSET_W-1:0] cur_off, rd_off, wr_off;
  logic                rd_valid, rd_dirty, data_we, meta_we, meta_valid, meta_dirty;
  logic [15:0]         rd_word, wr_data;

  // Outside IDLE the access latched at miss time is used, so a request
  // dropped mid-miss still completes consistently.
  assign any_req   = req_rd | req_wr;
  assign cur_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
  assign cur_wr    = (state == S_IDLE) ? req_wr    : lat_wr;
  assign idx       = INDEX_W'(addr_index(cur_addr, INDEX_W));
  assign cur_tag   = TAG_W'(addr_tag(cur_addr, INDEX_W));
  assign cur_off   = addr_offset(cur_addr);
  assign hit       = rd_valid && (rd_tag == cur_tag);
  assign rd_accept = (state == S_RD) && !mem_stall;
  assign capture   = trk_v[MEM_LAT-1] && ((state == S_RD) || (state == S_DRAIN));

  dcache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .index      (idx),
    .rd_offset  (rd_off),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_word    (rd_word),
    .data_we    (data_we),
    .wr_offset  (wr_off),
    .wr_data    (wr_data),
    .meta_we    (meta_we),
    .meta_tag   (cur_tag),
    .meta_valid (meta_valid),
    .meta_dirty (meta_dirty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Miss bookkeeping: latched request, issue/capture counters, read tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k         <= '0;
      cap_cnt   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
      trk_v     <= '0;
      trk_k     <= '0;
    end else begin
      if (state == S_IDLE && any_req && !hit) begin
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_wr    <= req_wr;
      end
      if ((state == S_WB || state == S_RD) && !mem_stall) k <= k + 1'b1;
      if (capture) cap_cnt <= cap_cnt + 1'b1;
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        trk_v[i] <= trk_v[i-1];
        trk_k[i] <= trk_k[i-1];
      end
      trk_v[0] <= rd_accept;
      trk_k[0] <= k;
    end
  end

  // Next-state, handshake outputs and array write controls.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    stall      = 1'b0;
    cache_req  = 1'b0;
    cache_hit  = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_data  = '0;
    rd_off     = cur_off;
    data_we    = 1'b0;
    wr_off     = cur_off;
    wr_data    = cur_wdata;
    meta_we    = 1'b0;
    meta_valid = 1'b0;
    meta_dirty = 1'b0;
    // Refill words land wherever the tracker says they belong.
    if (capture) begin
      data_we = 1'b1;
      wr_off  = trk_k[MEM_LAT-1];
      wr_data = mem_rdata;
    end
    case (state)
      S_IDLE: begin
        if (any_req) begin
          cache_req = 1'b1;
          if (hit) begin
            done      = 1'b1;
            cache_hit = 1'b1;
            resp_data = rd_word;
            if (req_wr) begin
              data_we    = 1'b1;
              meta_we    = 1'b1;
              meta_valid = 1'b1;
              meta_dirty = 1'b1;
            end
          end else begin
            stall      = 1'b1;
            state_next = (rd_valid && rd_dirty) ? S_WB : S_RD;
          end
        end
      end
      S_WB: begin
        stall     = 1'b1;
        mem_wr    = 1'b1;
        rd_off    = k;
        mem_wdata = rd_word;
        mem_addr  = {rd_tag, idx, k, 1'b0};
        if (!mem_stall && k == 2'd3) state_next = S_RD;
      end
      S_RD: begin
        stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = {cur_tag, idx, k, 1'b0};
        if (!mem_stall && k == 2'd3) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        stall = 1'b1;
        if (capture && cap_cnt == 2'd3) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        resp_data  = rd_word;
        meta_we    = 1'b1;
        meta_valid = 1'b1;
        meta_dirty = cur_wr;
        data_we    = cur_wr;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: scoreboard of expected access results
// and memory transactions, with a latency-accurate main-memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_rd, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic [15:0] resp_data;
  logic        done, stall, cache_req, cache_hit, mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_stall;
  logic [15:0] mem_rdata;

  typedef struct {
    logic [15:0] data;
    logic        hit;
    int          lat;
  } exp_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } memop_t;

  exp_t   exp_q[$];
  memop_t exp_mem_q[$];
  memop_t obs_mem_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  logic [15:0] mem_model [32768];
  logic [1:0]  pipe_v;
  logic [14:0] pipe_a [2];

  dcache_ctrl #(.INDEX_W(8), .MEM_LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_data (resp_data),
    .done      (done),
    .stall     (stall),
    .cache_req (cache_req),
    .cache_hit (cache_hit),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_stall (mem_stall),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dflt(input logic [15:0] byte_addr);
    return byte_addr ^ 16'h5000;
  endfunction

  // Memory contents: default pattern plus the two lines the scenarios use.
  initial begin
    for (int w = 0; w < 32768; w++) mem_model[w] <= dflt({w[14:0], 1'b0});
    mem_model[16'h0010 >> 1] <= 16'h00A0;
    mem_model[16'h0012 >> 1] <= 16'h00A1;
    mem_model[16'h0014 >> 1] <= 16'h00A2;
    mem_model[16'h0016 >> 1] <= 16'h00A3;
    mem_model[16'h0810 >> 1] <= 16'h00C0;
    mem_model[16'h0812 >> 1] <= 16'h00C1;
    mem_model[16'h0814 >> 1] <= 16'h00C2;
    mem_model[16'h0816 >> 1] <= 16'h00C3;
    pipe_v <= '0;
  end

  // Memory model: accepted reads return data two cycles later; writes land.
  always @(posedge clk) begin
    pipe_v    <= {pipe_v[0], mem_rd && !mem_stall};
    pipe_a[0] <= mem_addr[15:1];
    pipe_a[1] <= pipe_a[0];
    if (mem_wr && !mem_stall) mem_model[mem_addr[15:1]] <= mem_wdata;
  end
  assign mem_rdata = pipe_v[1] ? mem_model[pipe_a[1]] : 16'hDEAD;

  // Record every accepted memory transaction.
  always @(negedge clk) begin
    if (rst_n && (mem_rd || mem_wr) && !mem_stall)
      obs_mem_q.push_back('{wr: mem_wr, addr: mem_addr, data: (mem_wr ? mem_wdata : 16'h0)});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one access at posedge+1 and wait (bounded) for done.
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input int stall_from, input int stall_len,
                           output int lat, output logic [15:0] data, output logic hit,
                           output int nreq, output int nstall, output int first_memrd,
                           output logic dstall, output logic [15:0] saddr0,
                           output logic [15:0] saddr_last);
    req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
    lat = -1; data = 'x; hit = 'x; nreq = 0; nstall = 0; first_memrd = -1;
    dstall = 'x; saddr0 = 'x; saddr_last = 'x;
    for (int c = 0; c < 60; c++) begin
      mem_stall = (c >= stall_from) && (c < stall_from + stall_len);
      @(negedge clk);
      if (cache_req) nreq++;
      if (stall) nstall++;
      if (mem_rd && first_memrd < 0) first_memrd = c;
      if (mem_stall && c == stall_from) saddr0 = mem_addr;
      if (mem_stall) saddr_last = mem_addr;
      if (done) begin
        lat = c; data = resp_data; hit = cache_hit; dstall = stall;
      end
      @(posedge clk); #1;
      if (lat >= 0) break;
    end
    req_rd = 1'b0; req_wr = 1'b0; mem_stall = 1'b0;
    $display("[TB] access rd=%0b wr=%0b addr=%h lat=%0d data=%h hit=%0b", rd, wr, addr, lat, data, hit);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_rd = 0; req_wr = 0; req_addr = 0; req_wdata = 0; mem_stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({done, stall, cache_req, cache_hit, mem_rd, mem_wr} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000000", {done, stall, cache_req, cache_hit, mem_rd, mem_wr});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, resp_data} !== 48'h0) begin
      n_fail++; $display("FAIL reset_buses: got %h want 0", {mem_addr, mem_wdata, resp_data});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({done, stall, mem_rd, mem_wr} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 0000", {done, stall, mem_rd, mem_wr});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clean_miss();
    int lat, nreq, nst, fmr; logic [15:0] d, s0, s1; logic h, ds; exp_t e; memop_t em, om;
    exp_q.push_back('{data: 16'h00A0, hit: 1'b0, lat: 7});
    for (int i = 0; i < 4; i++) exp_mem_q.push_back('{wr: 1'b0, addr: 16'h0010 + 16'(2*i), data: 16'h0});
    do_access(1, 0, 16'h0010, 0, 99, 0, lat, d, h, nreq, nst, fmr, ds, s0, s1);
    e = exp_q.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL clean_miss_lat: got %0d want %0d", lat, e.lat); end
    n_tests++; if (d !== e.data) begin n_fail++; $display("FAIL clean_miss_data: got %h want %h", d, e.data); end
    n_tests++; if (h !== e.hit) begin n_fail++; $display("FAIL clean_miss_hit: got %b want %b", h, e.hit); end
    n_tests++; if (nst !== 7) begin n_fail++; $display("FAIL clean_miss_stall_cycles: got %0d want 7", nst); end
    n_tests++; if (nreq !== 1) begin n_fail++; $display("FAIL clean_miss_req_count: got %0d want 1", nreq); end
    n_tests++; if (fmr !== 1) begin n_fail++; $display("FAIL clean_miss_first_memrd: got t%0d want t1", fmr); end
    while (exp_mem_q.size() > 0) begin
      em = exp_mem_q.pop_front();
      n_tests++;
      if (obs_mem_q.size() == 0) begin
        n_fail++; $display("FAIL clean_miss_memop: got none want addr %h", em.addr);
      end else begin
        om = obs_mem_q.pop_front();
        if (om !== em) begin n_fail++; $display("FAIL clean_miss_memop: got %h want %h", om, em); end
      end
    end
    n_tests++; if (obs_mem_q.size() != 0) begin n_fail++; $display("FAIL clean_miss_extra_memops: got %0d want 0", obs_mem_q.size()); end
    obs_mem_q.delete();
  endtask

  task automatic test_read_hit();
    int lat, nreq, nst, fmr; logic [15:0] d, s0, s1; logic h, ds; exp_t e;
    exp_q.push_back('{data: 16'h00A2, hit: 1'b1, lat: 0});
    do_access(1, 0, 16'h0014, 0, 99, 0, lat, d, h, nreq, nst, fmr, ds, s0, s1);
    e = exp_q.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL hit_lat: got %0d want %0d", lat, e.lat); end
    n_tests++; if (d !== e.data) begin n_fail++; $display("FAIL hit_data: got %h want %h", d, e.data); end
    n_tests++; if (h !== e.hit) begin n_fail++; $display("FAIL hit_flag: got %b want %b", h, e.hit); end
    n_tests++; if (ds !== 1'b0) begin n_fail++; $display("FAIL hit_stall: got %b want 0", ds); end
    n_tests++; if (fmr !== -1 || obs_mem_q.size() != 0) begin n_fail++; $display("FAIL hit_no_mem: got first_memrd=%0d ops=%0d want none", fmr, obs_mem_q.size()); end
    obs_mem_q.delete();
  endtask

  task automatic test_dirty_miss();
    int lat, nreq, nst, fmr; logic [15:0] d, s0, s1; logic h, ds; exp_t e; memop_t em, om;
    logic [15:0] wb_data [4];
    wb_data[0] = 16'h00A0; wb_data[1] = 16'hBEEF; wb_data[2] = 16'h00A2; wb_data[3] = 16'h00A3;
    exp_q.push_back('{data: 16'h0000, hit: 1'b1, lat: 0});
    do_access(0, 1, 16'h0012, 16'hBEEF, 99, 0, lat, d, h, nreq, nst, fmr, ds, s0, s1);
    e = exp_q.pop_front();
    n_tests++; if (lat !== e.lat || h !== e.hit) begin n_fail++; $display("FAIL store_hit: got lat=%0d hit=%b want lat=%0d hit=%b", lat, h, e.lat, e.hit); end
    n_tests++; if (obs_mem_q.size() != 0) begin n_fail++; $display("FAIL store_hit_no_mem: got %0d ops want 0", obs_mem_q.size()); end
    obs_mem_q.delete();
    exp_q.push_back('{data: 16'h00C1, hit: 1'b0, lat: 11});
    for (int i = 0; i < 4; i++) exp_mem_q.push_back('{wr: 1'b1, addr: 16'h0010 + 16'(2*i), data: wb_data[i]});
    for (int i = 0; i < 4; i++) exp_mem_q.push_back('{wr: 1'b0, addr: 16'h0810 + 16'(2*i), data: 16'h0});
    do_access(1, 0, 16'h0812, 0, 99, 0, lat, d, h, nreq, nst, fmr, ds, s0, s1);
    e = exp_q.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL dirty_miss_lat: got %0d want %0d", lat, e.lat); end
    n_tests++; if (d !== e.data) begin n_fail++; $display("FAIL dirty_miss_data: got %h want %h", d, e.data); end
    n_tests++; if (h !== e.hit) begin n_fail++; $display("FAIL dirty_miss_hit: got %b want %b", h, e.hit); end
    n_tests++; if (fmr !== 5) begin n_fail++; $display("FAIL dirty_miss_first_memrd: got t%0d want t5", fmr); end
    while (exp_mem_q.size() > 0) begin
      em = exp_mem_q.pop_front();
      n_tests++;
      if (obs_mem_q.size() == 0) begin
        n_fail++; $display("FAIL dirty_miss_memop: got none want wr=%b addr=%h", em.wr, em.addr);
      end else begin
        om = obs_mem_q.pop_front();
        if (om !== em) begin n_fail++; $display("FAIL dirty_miss_memop: got %h want %h", om, em); end
      end
    end
    n_tests++; if (obs_mem_q.size() != 0) begin n_fail++; $display("FAIL dirty_miss_extra_memops: got %0d want 0", obs_mem_q.size()); end
    obs_mem_q.delete();
  endtask

  task automatic test_mem_stall();
    int lat, nreq, nst, fmr; logic [15:0] d, s0, s1; logic h, ds; exp_t e;
    // Line 2 now holds the clean 0x0810 block, so 0x0010 is a clean miss.
    exp_q.push_back('{data: 16'h00A0, hit: 1'b0, lat: 10});
    do_access(1, 0, 16'h0010, 0, 2, 3, lat, d, h, nreq, nst, fmr, ds, s0, s1);
    e = exp_q.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL memstall_lat: got %0d want %0d", lat, e.lat); end
    n_tests++; if (d !== e.data) begin n_fail++; $display("FAIL memstall_data: got %h want %h", d, e.data); end
    n_tests++; if (s0 !== 16'h0012 || s1 !== 16'h0012) begin n_fail++; $display("FAIL memstall_addr_hold: got %h..%h want 0012", s0, s1); end
    n_tests++; if (obs_mem_q.size() != 4) begin n_fail++; $display("FAIL memstall_read_count: got %0d want 4", obs_mem_q.size()); end
    obs_mem_q.delete();
    exp_q.push_back('{data: 16'hBEEF, hit: 1'b1, lat: 0});
    exp_q.push_back('{data: 16'h00A3, hit: 1'b1, lat: 0});
    do_access(1, 0, 16'h0012, 0, 99, 0, lat, d, h, nreq, nst, fmr, ds, s0, s1);
    e = exp_q.pop_front();
    n_tests++; if (d !== e.data || h !== e.hit) begin n_fail++; $display("FAIL memstall_word1: got %h/%b want %h/%b", d, h, e.data, e.hit); end
    do_access(1, 0, 16'h0016, 0, 99, 0, lat, d, h, nreq, nst, fmr, ds, s0, s1);
    e = exp_q.pop_front();
    n_tests++; if (d !== e.data || h !== e.hit) begin n_fail++; $display("FAIL memstall_word3: got %h/%b want %h/%b", d, h, e.data, e.hit); end
  endtask

  task automatic test_reset_abort();
    int lat, nreq, nst, fmr, req_total, hit_total; logic [15:0] d, s0, s1; logic h, ds; exp_t e;
    req_total = 0; hit_total = 0;
    req_rd = 1'b1; req_addr = 16'h0030;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (cache_req) req_total++;
      if (cache_hit) hit_total++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0; req_rd = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if ({stall, mem_rd, done} !== 3'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 000", {stall, mem_rd, done}); end
    @(posedge clk); #1;
    obs_mem_q.delete();
    exp_q.push_back('{data: dflt(16'h0030), hit: 1'b0, lat: 7});
    do_access(1, 0, 16'h0030, 0, 99, 0, lat, d, h, nreq, nst, fmr, ds, s0, s1);
    req_total += nreq;
    if (h === 1'b1) hit_total++;
    e = exp_q.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL abort_refetch_lat: got %0d want %0d", lat, e.lat); end
    n_tests++; if (d !== e.data) begin n_fail++; $display("FAIL abort_refetch_data: got %h want %h", d, e.data); end
    n_tests++; if (req_total !== 2) begin n_fail++; $display("FAIL abort_req_count: got %0d want 2", req_total); end
    n_tests++; if (hit_total !== 0) begin n_fail++; $display("FAIL abort_hit_count: got %0d want 0", hit_total); end
    n_tests++; if (obs_mem_q.size() != 4) begin n_fail++; $display("FAIL abort_read_count: got %0d want 4", obs_mem_q.size()); end
    obs_mem_q.delete();
  endtask

  task automatic test_rd_wr_both();
    int lat, nreq, nst, fmr; logic [15:0] d, s0, s1; logic h, ds; exp_t e;
    exp_q.push_back('{data: 16'h00A3, hit: 1'b0, lat: 7});
    exp_q.push_back('{data: 16'h0000, hit: 1'b1, lat: 0});
    exp_q.push_back('{data: 16'h1234, hit: 1'b1, lat: 0});
    do_access(1, 0, 16'h0016, 0, 99, 0, lat, d, h, nreq, nst, fmr, ds, s0, s1);
    e = exp_q.pop_front();
    n_tests++; if (d !== e.data || lat !== e.lat) begin n_fail++; $display("FAIL both_fill: got %h lat=%0d want %h lat=%0d", d, lat, e.data, e.lat); end
    do_access(1, 1, 16'h0016, 16'h1234, 99, 0, lat, d, h, nreq, nst, fmr, ds, s0, s1);
    e = exp_q.pop_front();
    n_tests++; if (h !== e.hit || lat !== e.lat) begin n_fail++; $display("FAIL both_store_hit: got hit=%b lat=%0d want hit=%b lat=%0d", h, lat, e.hit, e.lat); end
    do_access(1, 0, 16'h0016, 0, 99, 0, lat, d, h, nreq, nst, fmr, ds, s0, s1);
    e = exp_q.pop_front();
    n_tests++; if (d !== e.data || h !== e.hit) begin n_fail++; $display("FAIL both_readback: got %h/%b want %h/%b", d, h, e.data, e.hit); end
    obs_mem_q.delete();
  endtask

  task automatic test_back_to_back();
    int lat, nreq, nst, fmr; logic [15:0] d, s0, s1; logic h, ds; exp_t e;
    logic [15:0] addrs [3];
    addrs[0] = 16'h0010; addrs[1] = 16'h0012; addrs[2] = 16'h0016;
    exp_q.push_back('{data: 16'h00A0, hit: 1'b1, lat: 0});
    exp_q.push_back('{data: 16'hBEEF, hit: 1'b1, lat: 0});
    exp_q.push_back('{data: 16'h1234, hit: 1'b1, lat: 0});
    for (int i = 0; i < 3; i++) begin
      do_access(1, 0, addrs[i], 0, 99, 0, lat, d, h, nreq, nst, fmr, ds, s0, s1);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e.data || h !== e.hit || lat !== e.lat) begin
        n_fail++; $display("FAIL b2b_%0d: got %h/%b/lat%0d want %h/%b/lat%0d", i, d, h, lat, e.data, e.hit, e.lat);
      end
    end
    n_tests++; if (obs_mem_q.size() != 0) begin n_fail++; $display("FAIL b2b_no_mem: got %0d ops want 0", obs_mem_q.size()); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_read_hit();
    test_dirty_miss();
    test_mem_stall();
    test_reset_abort();
    test_rd_wr_both();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
